// File: rtl/wb_sram_ctrl.sv
// Wishbone classic slave driving one 256x32 single-RW/single-R SRAM macro through its RW port.
// One transaction at a time; every macro and bus output is registered.
module wb_sram_ctrl #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          DEPTH_LOG2 = 8,
    parameter int          RD_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_we_i,
    input  logic [3:0]            wb_sel_i,
    input  logic [31:0]           wb_adr_i,
    input  logic [31:0]           wb_dat_i,
    output logic [31:0]           wb_dat_o,
    output logic                  wb_ack_o,
    output logic                  wb_err_o,
    output logic                  sram_clk0,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [7:0]            sram_wmask0,
    output logic [DEPTH_LOG2-1:0] sram_addr0,
    output logic [31:0]           sram_din0,
    input  logic [31:0]           sram_dout0,
    output logic                  sram_clk1,
    output logic                  sram_csb1,
    output logic [DEPTH_LOG2-1:0] sram_addr1
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RDWAIT = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic [1:0] RD_LAT_C = 2'(RD_LAT);

    state_t     state_r;
    logic [1:0] cnt_r;
    logic       we_r;
    logic       req_s;
    logic       in_window_s;
    logic       adr_unused_s;

    assign req_s        = wb_cyc_i & wb_stb_i;
    assign in_window_s  = (wb_adr_i[31:DEPTH_LOG2+2] == BASE_ADDR[31:DEPTH_LOG2+2]);
    assign adr_unused_s = &{1'b0, wb_adr_i[1:0]};

    assign sram_clk0  = clk;
    assign sram_clk1  = clk;
    assign sram_csb1  = 1'b1;
    assign sram_addr1 = {DEPTH_LOG2{1'b0}};

    // Transaction FSM with registered macro controls and bus responses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= 2'd0;
            we_r        <= 1'b0;
            sram_csb0   <= 1'b1;
            sram_web0   <= 1'b1;
            sram_wmask0 <= 8'h00;
            sram_addr0  <= {DEPTH_LOG2{1'b0}};
            sram_din0   <= 32'h0000_0000;
            wb_ack_o    <= 1'b0;
            wb_err_o    <= 1'b0;
            wb_dat_o    <= 32'h0000_0000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_s) begin
                        if (!in_window_s) begin
                            wb_err_o <= 1'b1;
                            state_r  <= RESP;
                        end else if (wb_we_i && (wb_sel_i == 4'b0000)) begin
                            wb_ack_o <= 1'b1;
                            state_r  <= RESP;
                        end else begin
                            sram_addr0  <= wb_adr_i[DEPTH_LOG2+1:2];
                            sram_din0   <= wb_dat_i;
                            sram_wmask0 <= {4'b0000, wb_sel_i};
                            sram_csb0   <= 1'b0;
                            sram_web0   <= ~wb_we_i;
                            we_r        <= wb_we_i;
                            state_r     <= ACCESS;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ACCESS: begin
                    // The macro has already captured a write on this edge, so an abort cannot undo it
                    if (!wb_cyc_i) begin
                        sram_csb0 <= 1'b1;
                        sram_web0 <= 1'b1;
                        state_r   <= IDLE;
                    end else if (we_r) begin
                        sram_csb0 <= 1'b1;
                        sram_web0 <= 1'b1;
                        wb_ack_o  <= 1'b1;
                        state_r   <= RESP;
                    end else begin
                        cnt_r   <= RD_LAT_C;
                        state_r <= RDWAIT;
                    end
                end
                RDWAIT: begin
                    // Chip select stays low on the same word; repeated reads are harmless
                    if (!wb_cyc_i) begin
                        sram_csb0 <= 1'b1;
                        sram_web0 <= 1'b1;
                        state_r   <= IDLE;
                    end else if (cnt_r == 2'd1) begin
                        wb_dat_o  <= sram_dout0;
                        wb_ack_o  <= 1'b1;
                        sram_csb0 <= 1'b1;
                        state_r   <= RESP;
                    end else begin
                        cnt_r <= cnt_r - 2'd1;
                    end
                end
                RESP: begin
                    wb_ack_o <= 1'b0;
                    wb_err_o <= 1'b0;
                    state_r  <= IDLE;
                end
                default: begin
                    sram_csb0 <= 1'b1;
                    sram_web0 <= 1'b1;
                    wb_ack_o  <= 1'b0;
                    wb_err_o  <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_sram_ctrl.sv
// Bench for wb_sram_ctrl: a transaction-level model predicts per-cycle bus/macro activity,
// a single compare process checks it every cycle, and literal pins anchor the model.
module tb_wb_sram_ctrl;

    localparam logic [31:0] BASE   = 32'h0000_0000;
    localparam int          RD_LAT = 1;
    localparam int          NCYC   = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
    logic [3:0]  wb_sel = 4'h0;
    logic [31:0] wb_adr = 32'h0, wb_dat = 32'h0;
    logic [31:0] wb_dat_o;
    logic        wb_ack, wb_err;
    logic        sram_clk0, sram_csb0, sram_web0, sram_clk1, sram_csb1;
    logic [7:0]  sram_wmask0, sram_addr0, sram_addr1;
    logic [31:0] sram_din0;
    logic [31:0] sram_dout0 = 32'h0;

    always #5 clk = ~clk;

    wb_sram_ctrl #(.BASE_ADDR(BASE), .DEPTH_LOG2(8), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst),
        .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_we_i(wb_we), .wb_sel_i(wb_sel),
        .wb_adr_i(wb_adr), .wb_dat_i(wb_dat), .wb_dat_o(wb_dat_o),
        .wb_ack_o(wb_ack), .wb_err_o(wb_err),
        .sram_clk0(sram_clk0), .sram_csb0(sram_csb0), .sram_web0(sram_web0),
        .sram_wmask0(sram_wmask0), .sram_addr0(sram_addr0), .sram_din0(sram_din0),
        .sram_dout0(sram_dout0), .sram_clk1(sram_clk1), .sram_csb1(sram_csb1),
        .sram_addr1(sram_addr1)
    );

    // Behavioural SRAM macro: synchronous capture, read data valid after the edge
    logic [31:0] macro_mem [256];
    initial for (int i = 0; i < 256; i++) macro_mem[i] = 32'h0;
    always @(posedge clk) begin
        if (!sram_csb0) begin
            if (!sram_web0) begin
                for (int b = 0; b < 4; b++)
                    if (sram_wmask0[b]) macro_mem[sram_addr0][8*b +: 8] <= sram_din0[8*b +: 8];
            end else begin
                sram_dout0 <= macro_mem[sram_addr0];
            end
        end
    end

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    // Transaction model state and per-cycle expectations
    logic [31:0] model_mem [256];
    int          free_edge = 0;
    bit          e_ack [NCYC];
    bit          e_err [NCYC];
    bit          e_csb [NCYC];
    bit          e_web [NCYC];
    bit          e_rd  [NCYC];
    logic [31:0] e_dat [NCYC];
    logic [7:0]  e_addr[NCYC];
    int          pin_kind[NCYC];
    logic [31:0] pin_val [NCYC];
    bit          chk_en = 1'b0;
    int          errors = 0;
    int          checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h, want %h", name, cycle, act, exp);
        end
    endtask

    // Compare process: reset values on reset entry, full output check every cycle otherwise
    logic [31:0] hold_dat = 32'h0;
    bit          rst_done = 1'b0;
    initial begin
        forever begin
            @(negedge clk or posedge rst);
            if (rst) begin
                hold_dat = 32'h0;
                if (!rst_done) begin
                    rst_done = 1'b1;
                    #1;
                    check("rst_csb0", sram_csb0, 32'h1);
                    check("rst_web0", sram_web0, 32'h1);
                    check("rst_wmask0", sram_wmask0, 32'h0);
                    check("rst_addr0", sram_addr0, 32'h0);
                    check("rst_din0", sram_din0, 32'h0);
                    check("rst_ack", wb_ack, 32'h0);
                    check("rst_err", wb_err, 32'h0);
                    check("rst_dat_o", wb_dat_o, 32'h0);
                    check("rst_csb1", sram_csb1, 32'h1);
                end
            end else begin
                rst_done = 1'b0;
                if (chk_en && cycle < NCYC) begin
                    if (e_ack[cycle] && e_rd[cycle]) hold_dat = e_dat[cycle];
                    check("ack", wb_ack, 32'(e_ack[cycle]));
                    check("err", wb_err, 32'(e_err[cycle]));
                    check("dat_o", wb_dat_o, hold_dat);
                    check("csb0", sram_csb0, 32'(!e_csb[cycle]));
                    check("web0", sram_web0, 32'(!e_web[cycle]));
                    if (e_csb[cycle]) check("addr0", sram_addr0, 32'(e_addr[cycle]));
                    case (pin_kind[cycle])
                        0: ;
                        1: check("pin_addr0", sram_addr0, pin_val[cycle]);
                        2: check("pin_wmask0", sram_wmask0, pin_val[cycle]);
                        3: check("pin_ack", wb_ack, pin_val[cycle]);
                        4: check("pin_rdata", wb_ack ? wb_dat_o : 32'hxxxx_xxxx, pin_val[cycle]);
                        5: check("pin_err_only", {30'h0, wb_ack, wb_err}, pin_val[cycle]);
                        6: check("pin_csb0", sram_csb0, pin_val[cycle]);
                        default: ;
                    endcase
                end
            end
        end
    end

    function automatic int next_e0();
        return (cycle + 1 > free_edge) ? cycle + 1 : free_edge;
    endfunction

    // Present a request at a falling edge and hold it until the model's response cycle
    task automatic issue(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel);
        int          n0, resp, word;
        logic [31:0] off;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat = dat; wb_sel = sel;
        n0   = next_e0();
        off  = adr - BASE;
        word = int'((off / 32'd4) % 32'd256);
        if (off >= 32'd1024) begin
            resp = n0;
            e_err[resp] = 1'b1;
        end else if (we && sel == 4'b0000) begin
            resp = n0;
            e_ack[resp] = 1'b1;
        end else if (we) begin
            e_csb[n0] = 1'b1; e_web[n0] = 1'b1; e_addr[n0] = word[7:0];
            for (int b = 0; b < 4; b++)
                if (sel[b]) model_mem[word][8*b +: 8] = dat[8*b +: 8];
            resp = n0 + 1;
            e_ack[resp] = 1'b1;
        end else begin
            for (int k = n0; k <= n0 + RD_LAT; k++) begin
                e_csb[k] = 1'b1; e_addr[k] = word[7:0];
            end
            resp = n0 + 1 + RD_LAT;
            e_ack[resp] = 1'b1; e_rd[resp] = 1'b1; e_dat[resp] = model_mem[word];
        end
        free_edge = resp + 2;
        while (cycle < resp) @(negedge clk);
    endtask

    task automatic idle(input int n);
        wb_cyc = 1'b0; wb_stb = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic start_read(input logic [31:0] adr, output int n0);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = adr; wb_sel = 4'hF;
        n0 = next_e0();
        e_csb[n0] = 1'b1;     e_addr[n0] = adr[9:2];
        e_csb[n0 + 1] = 1'b1; e_addr[n0 + 1] = adr[9:2];
        while (cycle < n0 + 1) @(negedge clk);
    endtask

    int nx;

    initial begin
        for (int i = 0; i < 256; i++) model_mem[i] = 32'h0;
        for (int i = 0; i < NCYC; i++) begin
            e_ack[i] = 1'b0; e_err[i] = 1'b0; e_csb[i] = 1'b0; e_web[i] = 1'b0; e_rd[i] = 1'b0;
            e_dat[i] = 32'h0; e_addr[i] = 8'h0; pin_kind[i] = 0; pin_val[i] = 32'h0;
        end
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;
        free_edge = cycle + 1;
        idle(2);

        // Full write then read of the same word
        nx = cycle + 1;
        pin_kind[nx] = 1; pin_val[nx] = 32'h04;
        pin_kind[nx + 1] = 2; pin_val[nx + 1] = 32'h0F;
        issue(1'b1, BASE + 32'h10, 32'hDEAD_BEEF, 4'hF);
        idle(2);
        nx = cycle + 1;
        pin_kind[nx + 2] = 4; pin_val[nx + 2] = 32'hDEAD_BEEF;
        issue(1'b0, BASE + 32'h10, 32'h0, 4'hF);
        idle(2);

        // Single-lane write; read back via an address with nonzero low bits
        issue(1'b1, BASE + 32'h10, 32'h0000_5500, 4'b0010);
        idle(2);
        nx = cycle + 1;
        pin_kind[nx + 2] = 4; pin_val[nx + 2] = 32'hDEAD_55EF;
        issue(1'b0, BASE + 32'h13, 32'h0, 4'hF);
        idle(2);

        // Out-of-window read, then zero-lane write that must not touch the macro
        nx = cycle + 1;
        pin_kind[nx] = 5; pin_val[nx] = 32'h1;
        pin_kind[nx + 1] = 5; pin_val[nx + 1] = 32'h0;
        issue(1'b0, BASE + 32'h400, 32'h0, 4'hF);
        idle(2);
        issue(1'b1, BASE + 32'h20, 32'h1234_5678, 4'b0000);
        idle(2);
        issue(1'b0, BASE + 32'h20, 32'h0, 4'hF);
        idle(2);

        // Strobe held across four writes and four reads; each write takes IDLE+ACCESS+RESP
        nx = cycle + 1;
        pin_kind[nx + 1] = 3;  pin_val[nx + 1] = 32'h1;
        pin_kind[nx + 4] = 3;  pin_val[nx + 4] = 32'h1;
        pin_kind[nx + 7] = 3;  pin_val[nx + 7] = 32'h1;
        pin_kind[nx + 10] = 3; pin_val[nx + 10] = 32'h1;
        issue(1'b1, BASE + 32'h0, 32'hA5A5_0000, 4'hF);
        issue(1'b1, BASE + 32'h4, 32'h0123_4567, 4'hF);
        issue(1'b1, BASE + 32'h8, 32'h89AB_CDEF, 4'hF);
        issue(1'b1, BASE + 32'hC, 32'hFFFF_0001, 4'hF);
        nx = cycle + 2;
        pin_kind[nx + 2] = 4;  pin_val[nx + 2] = 32'hA5A5_0000;
        pin_kind[nx + 6] = 4;  pin_val[nx + 6] = 32'h0123_4567;
        pin_kind[nx + 10] = 4; pin_val[nx + 10] = 32'h89AB_CDEF;
        pin_kind[nx + 14] = 4; pin_val[nx + 14] = 32'hFFFF_0001;
        issue(1'b0, BASE + 32'h0, 32'h0, 4'hF);
        issue(1'b0, BASE + 32'h4, 32'h0, 4'hF);
        issue(1'b0, BASE + 32'h8, 32'h0, 4'hF);
        issue(1'b0, BASE + 32'hC, 32'h0, 4'hF);
        idle(2);

        // Outer lanes only
        issue(1'b1, BASE + 32'h4, 32'hAABB_CCDD, 4'b1001);
        idle(2);

        // Abort a read in its wait state; the next read must still complete
        start_read(BASE + 32'hC, nx);
        wb_cyc = 1'b0; wb_stb = 1'b0;
        pin_kind[nx + 2] = 6; pin_val[nx + 2] = 32'h1;
        while (cycle < nx + 2) @(negedge clk);
        free_edge = nx + 3;
        nx = next_e0();
        pin_kind[nx + 2] = 4; pin_val[nx + 2] = 32'hAA23_45DD;
        issue(1'b0, BASE + 32'h4, 32'h0, 4'hF);
        idle(2);

        // Reset in the middle of a read wait, then a clean transaction
        start_read(BASE + 32'hC, nx);
        #2 rst = 1'b1;
        wb_cyc = 1'b0; wb_stb = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        free_edge = cycle + 1;
        @(negedge clk);
        nx = next_e0();
        pin_kind[nx + 2] = 4; pin_val[nx + 2] = 32'h89AB_CDEF;
        issue(1'b0, BASE + 32'h8, 32'h0, 4'hF);
        idle(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

endmodule
